// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: opcode encodings shared with ALU control decode
package alu_exec_unit_pkg;

  typedef enum logic [3:0] {
    ALU_AND      = 4'b0000,
    ALU_OR       = 4'b0001,
    ALU_ADD      = 4'b0010,
    ALU_XOR      = 4'b0011,
    ALU_NOT      = 4'b0100,
    ALU_SUBTRACT = 4'b0110,
    ALU_JUMP     = 4'b1100
  } alu_op_e;

  localparam int LINK_OFFSET = 4;
  localparam int CNT_W       = 8;

  function automatic logic is_legal(input logic [3:0] code);
    return code inside {ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOT, ALU_SUBTRACT, ALU_JUMP};
  endfunction

endpackage

// File: rtl/alu_exec_unit_core.sv
// alu_core: combinational ALU compute (result, carry, illegal) for one code
module alu_core
  import alu_exec_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   code,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         illegal
);

  logic [W:0] sum;
  logic [W:0] link;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign link = {1'b0, a} + (W+1)'(LINK_OFFSET);

  // decode the code into result and carry; unknown codes yield zero
  always_comb begin
    result  = '0;
    carry   = 1'b0;
    illegal = !is_legal(code);
    case (code)
      ALU_AND:      result = a & b;
      ALU_OR:       result = a | b;
      ALU_ADD:      {carry, result} = sum;
      ALU_XOR:      result = a ^ b;
      ALU_NOT:      result = ~a;
      ALU_SUBTRACT: begin
        result = a - b;
        carry  = a >= b;
      end
      ALU_JUMP:     {carry, result} = link;
      default:      result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage valid/ready ALU pipeline with flush and illegal-op counter
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             zero,
  output logic             carry,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic           s1_valid;
  logic           s1_advance;
  logic [3:0]     s1_code;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic [W-1:0]   core_result;
  logic           core_carry;
  logic           core_illegal;

  assign s1_advance = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;

  alu_core #(.W(W)) u_core (
    .code    (s1_code),
    .a       (s1_a),
    .b       (s1_b),
    .result  (core_result),
    .carry   (core_carry),
    .illegal (core_illegal)
  );

  // S1: capture the offered operation; flush empties the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_code  <= alu_control;
      s1_a     <= op_a;
      s1_b     <= op_b;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: register computed result and flags; data only moves on advance so it holds under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= 1'b1;
      result    <= core_result;
      zero      <= core_result == '0;
      carry     <= core_carry;
      illegal   <= core_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // count illegal operations entering S2, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (!flush && s1_advance && core_illegal && illegal_cnt != '1)
      illegal_cnt <= illegal_cnt + 1'b1;
  end

endmodule
